// File: rtl/arb_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
package arb_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/arb_prio_sel.sv
// Grant selection between fetch and data requests.
// ARB_ROUND_ROBIN_EN adds a last_grant register so that ties alternate.
module arb_prio_sel
  import arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst,
  input  logic grant_take,
`endif
  input  logic i_req,
  input  logic d_req,
  output logic gnt,
  output logic any_req
);

  assign any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    gnt = GNT_I;
    if (i_req && d_req) gnt = ~last_grant;
    else if (d_req)     gnt = GNT_D;
  end

  // Reset to "last = fetch" so the first tie goes to the data port.
  always_ff @(posedge clk) begin
    if (rst)             last_grant <= GNT_I;
    else if (grant_take) last_grant <= gnt;
  end
`else
  assign gnt = d_req ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the core.
// Optional round-robin tie-breaking is enabled with ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       winner;
  logic       gnt;
  logic       any_req;

  arb_prio_sel u_sel (
`ifdef ARB_ROUND_ROBIN_EN
    .clk        (clk),
    .rst        (rst),
    .grant_take (state == ST_IDLE && any_req),
`endif
    .i_req      (i_req),
    .d_req      (d_req),
    .gnt        (gnt),
    .any_req    (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      winner    <= GNT_I;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state     <= ST_ACCESS;
            winner    <= gnt;
            cnt       <= LAT_M1;
            mem_en    <= 1'b1;
            mem_we    <= (gnt == GNT_D) && d_we;
            mem_addr  <= (gnt == GNT_D) ? d_addr : i_addr;
            mem_wdata <= (gnt == GNT_D) ? d_wdata : '0;
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= ST_DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            // Stores leave both read-data registers untouched.
            if (!mem_we) begin
              if (winner == GNT_D) d_rdata <= mem_rdata;
              else                 i_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign i_ready = (state == ST_DONE) && (winner == GNT_I);
  assign d_ready = (state == ST_DONE) && (winner == GNT_D);

endmodule
